// File: rtl/cram_access_arbiter_pkg.sv
// Shared grant/tag encodings and the arbitration priority rule for the cart-RAM arbiter.
package cram_access_arbiter_pkg;

  typedef logic [1:0] gnt_t;

  localparam gnt_t GNT_NONE = 2'd0;
  localparam gnt_t GNT_CPU  = 2'd1;
  localparam gnt_t GNT_MBC  = 2'd2;
  localparam gnt_t GNT_SS   = 2'd3;

  localparam int RD_LAT = 2;

  // While the savestate engine sleeps the system it owns the RAM and the CPU is ignored.
  function automatic gnt_t pick_grant(
    input logic cpu_req,
    input logic mbc_req,
    input logic ss_req,
    input logic sleep,
    input logic starved
  );
    gnt_t gnt;
    gnt = GNT_NONE;
    if (sleep) begin
      if (ss_req)       gnt = GNT_SS;
      else if (mbc_req) gnt = GNT_MBC;
    end else if (cpu_req) begin
      gnt = GNT_CPU;
    end else if (ss_req && starved) begin
      gnt = GNT_SS;
    end else if (mbc_req) begin
      gnt = GNT_MBC;
    end else if (ss_req) begin
      gnt = GNT_SS;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/cram_arb_rdpipe.sv
// Read-tag shift register: follows each issued read to the RAM and steers ram_q back
// to the requester that asked for it.
module cram_arb_rdpipe
  import cram_access_arbiter_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset_n,
  input  gnt_t       issue_tag,
  input  logic [7:0] ram_q,
  output logic [7:0] cpu_rdata,
  output logic       cpu_rvalid,
  output logic [7:0] ss_rdata,
  output logic       ss_rvalid,
  output logic       in_flight
);

  gnt_t tag_pipe [RD_LAT];

  // ram_q belongs to the read whose tag sits one stage before the output stage.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= GNT_NONE;
      cpu_rdata <= '0;
      ss_rdata  <= '0;
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (tag_pipe[RD_LAT-2] == GNT_CPU) cpu_rdata <= ram_q;
      if (tag_pipe[RD_LAT-2] == GNT_SS)  ss_rdata  <= ram_q;
    end
  end

  assign cpu_rvalid = (tag_pipe[RD_LAT-1] == GNT_CPU);
  assign ss_rvalid  = (tag_pipe[RD_LAT-1] == GNT_SS);

  always_comb begin
    in_flight = 1'b0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight | (tag_pipe[i] != GNT_NONE);
  end

endmodule

// File: rtl/cram_access_arbiter.sv
// Shares the single cart-RAM port between CPU, MBC auto-writes and the savestate engine,
// issuing at most one registered RAM operation per cycle.
module cram_access_arbiter
  import cram_access_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 17,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              sleep_savestate,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              mbc_req,
  input  logic [ADDR_W-1:0] mbc_addr,
  input  logic [7:0]        mbc_wdata,
  output logic              mbc_ack,
  input  logic              ss_req,
  input  logic              ss_we,
  input  logic [ADDR_W-1:0] ss_addr,
  input  logic [7:0]        ss_wdata,
  output logic              ss_ack,
  output logic [7:0]        ss_rdata,
  output logic              ss_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_di,
  input  logic [7:0]        ram_q,
  output logic              busy
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  gnt_t              gnt_next;
  gnt_t              gnt_q;
  gnt_t              rd_tag;
  logic [WAIT_W-1:0] wait_cnt;
  logic              starved;
  logic              in_flight;

  assign starved  = (wait_cnt == WAIT_W'(MAX_WAIT));
  assign gnt_next = pick_grant(cpu_req, mbc_req, ss_req, sleep_savestate, starved);

  always_comb begin
    rd_tag = GNT_NONE;
    if (gnt_next == GNT_CPU && !cpu_we) rd_tag = GNT_CPU;
    if (gnt_next == GNT_SS  && !ss_we)  rd_tag = GNT_SS;
  end

  // RAM port is fully registered; ram_addr/ram_di simply hold through idle cycles.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      gnt_q    <= GNT_NONE;
      ram_addr <= '0;
      ram_wr   <= 1'b0;
      ram_di   <= '0;
    end else begin
      gnt_q  <= gnt_next;
      ram_wr <= 1'b0;
      case (gnt_next)
        GNT_CPU: begin
          ram_addr <= cpu_addr;
          ram_wr   <= cpu_we;
          ram_di   <= cpu_wdata;
        end
        GNT_MBC: begin
          ram_addr <= mbc_addr;
          ram_wr   <= 1'b1;
          ram_di   <= mbc_wdata;
        end
        GNT_SS: begin
          ram_addr <= ss_addr;
          ram_wr   <= ss_we;
          ram_di   <= ss_wdata;
        end
        default: ;
      endcase
    end
  end

  // Counts how long a pending savestate request has been passed over; a saturated
  // count lifts SS above MBC (never above the CPU).
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (!ss_req || gnt_next == GNT_SS) begin
      wait_cnt <= '0;
    end else if (!starved) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign mbc_ack = (gnt_q == GNT_MBC);
  assign ss_ack  = (gnt_q == GNT_SS);

  cram_arb_rdpipe u_rdpipe (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .issue_tag  (rd_tag),
    .ram_q      (ram_q),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .ss_rdata   (ss_rdata),
    .ss_rvalid  (ss_rvalid),
    .in_flight  (in_flight)
  );

  assign busy = mbc_req | ss_req | in_flight;

endmodule
